// File: rtl/pci_pkg.sv
// Shared definitions for the PCI target controller: bus command codes,
// controller state encoding, default storage depth and the word-index
// wrap helper.
package pci_pkg;

   localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
   localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

   localparam int DEFAULT_NUM_WORDS = 3;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_DECODE     = 3'd1,
      ST_RD_TURN    = 3'd2,
      ST_DATA       = 3'd3,
      ST_TURNAROUND = 3'd4
   } tgt_state_t;

   // Next storage word index, wrapping from the last word back to word 0.
   function automatic logic [1:0] next_index(input logic [1:0] idx, input int num_words);
      logic [1:0] res;
      if ({30'd0, idx} >= 32'(num_words - 1)) res = 2'd0;
      else res = idx + 2'd1;
      return res;
   endfunction

endpackage

// File: rtl/pci_addr_decode.sv
// Combinational address-phase decoder: reports whether the AD/CBE_n pair
// is a memory read or write that falls inside this target's window, and
// which storage word it starts at.
module pci_addr_decode
   import pci_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int          NUM_WORDS = DEFAULT_NUM_WORDS
) (
   input  logic [31:0] ad_i,
   input  logic [3:0]  cbe_n_i,
   output logic        hit_o,
   output logic        is_write_o,
   output logic [1:0]  index_o
);

   logic addr_match;
   logic cmd_ok;
   logic idx_ok;
   logic unused_ad_bits;

   // The two lowest address bits carry burst ordering, which this target ignores.
   assign unused_ad_bits = ^ad_i[1:0];

   // Window, command and word-range qualification of the address phase.
   always_comb begin
      addr_match = (ad_i[31:4] == BASE_ADDR[31:4]);
      cmd_ok     = (cbe_n_i == CMD_MEM_READ) || (cbe_n_i == CMD_MEM_WRITE);
      idx_ok     = ({30'd0, ad_i[3:2]} < 32'(NUM_WORDS));
      hit_o      = addr_match && cmd_ok && idx_ok;
      is_write_o = (cbe_n_i == CMD_MEM_WRITE);
      index_o    = ad_i[3:2];
   end

endmodule

// File: rtl/pci_target_ctrl.sv
// PCI target sequencer for the three-word storage. Claims memory
// read/write bursts hitting BASE_ADDR, drives DEVSEL#/TRDY#/STOP# and
// issues per-phase storage strobes, word index and byte enables.
// Optional build macro PCI_TGT_RETRY_EN: disconnect (STOP#) after
// RETRY_LIMIT consecutive storage wait cycles.
//
// Handshake: a data phase transfers on the rising edge that samples both
// IRDY_n and TRDY_n low. TRDY_n is registered, so st_ready sampled at one
// edge decides TRDY_n for the following cycle; st_we pulses in the cycle
// after a write phase transfers.
module pci_target_ctrl
   import pci_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int          NUM_WORDS   = DEFAULT_NUM_WORDS,
   parameter int          RETRY_LIMIT = 8
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        FRAME_n,
   input  logic        IRDY_n,
   input  logic [31:0] AD,
   input  logic [3:0]  CBE_n,
   input  logic        st_ready,
   output logic        DEVSEL_n,
   output logic        TRDY_n,
   output logic        STOP_n,
   output logic        st_re,
   output logic        st_we,
   output logic [1:0]  st_addr,
   output logic [3:0]  st_be,
   output logic [2:0]  state_dbg_o
);

   tgt_state_t state_q, state_d;
   logic       frame_prev_q;
   logic       is_wr_q, is_wr_d;
   logic [1:0] index_q, index_d;
   logic       devsel_n_q, devsel_n_d;
   logic       trdy_n_q, trdy_n_d;
   logic       st_re_q, st_re_d;
   logic       st_we_q, st_we_d;
   logic [1:0] st_addr_q, st_addr_d;
   logic [3:0] st_be_q, st_be_d;

   logic       dec_hit;
   logic       dec_is_write;
   logic [1:0] dec_index;
   logic       phase_done;

`ifdef PCI_TGT_RETRY_EN
   localparam int CNT_W = $clog2(RETRY_LIMIT + 1);
   logic             stop_n_q, stop_n_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
   localparam int unused_retry_limit = RETRY_LIMIT;
`endif

   pci_addr_decode #(
      .BASE_ADDR (BASE_ADDR),
      .NUM_WORDS (NUM_WORDS)
   ) u_decode (
      .ad_i       (AD),
      .cbe_n_i    (CBE_n),
      .hit_o      (dec_hit),
      .is_write_o (dec_is_write),
      .index_o    (dec_index)
   );

   assign phase_done = (state_q == ST_DATA) && !IRDY_n && !trdy_n_q;

   // Next-state and registered-output decisions; everything released by default.
   always_comb begin
      state_d    = state_q;
      is_wr_d    = is_wr_q;
      index_d    = index_q;
      devsel_n_d = 1'b1;
      trdy_n_d   = 1'b1;
      st_re_d    = 1'b0;
      st_we_d    = 1'b0;
      st_addr_d  = st_addr_q;
      st_be_d    = st_be_q;
`ifdef PCI_TGT_RETRY_EN
      stop_n_d   = 1'b1;
      wait_cnt_d = '0;
`endif
      case (state_q)
         ST_IDLE: begin
            // Only a fresh FRAME# falling edge starts an address phase.
            if (!FRAME_n && frame_prev_q && dec_hit) begin
               state_d = ST_DECODE;
               is_wr_d = dec_is_write;
               index_d = dec_index;
            end
         end
         ST_DECODE: begin
            devsel_n_d = 1'b0;
            st_addr_d  = index_q;
            if (is_wr_q) begin
               state_d  = ST_DATA;
               trdy_n_d = ~st_ready;
            end else begin
               state_d = ST_RD_TURN;
               st_re_d = 1'b1;
            end
         end
         ST_RD_TURN: begin
            devsel_n_d = 1'b0;
            st_re_d    = 1'b1;
            state_d    = ST_DATA;
            trdy_n_d   = ~st_ready;
         end
         ST_DATA: begin
            if (phase_done) begin
               index_d = next_index(index_q, NUM_WORDS);
               if (is_wr_q) begin
                  st_we_d   = 1'b1;
                  st_addr_d = index_q;
                  st_be_d   = ~CBE_n;
               end else begin
                  st_addr_d = index_d;
               end
               if (FRAME_n) begin
                  state_d = ST_TURNAROUND;
               end else begin
                  devsel_n_d = 1'b0;
                  st_re_d    = !is_wr_q;
                  trdy_n_d   = ~st_ready;
               end
            end else if (FRAME_n && IRDY_n) begin
               state_d = ST_TURNAROUND;
`ifdef PCI_TGT_RETRY_EN
            end else if (!stop_n_q) begin
               // Disconnect held until the master drops FRAME#.
               if (FRAME_n) begin
                  state_d = ST_TURNAROUND;
               end else begin
                  devsel_n_d = 1'b0;
                  st_re_d    = !is_wr_q;
                  stop_n_d   = 1'b0;
               end
`endif
            end else begin
               devsel_n_d = 1'b0;
               st_re_d    = !is_wr_q;
               trdy_n_d   = ~st_ready;
`ifdef PCI_TGT_RETRY_EN
               if (!st_ready) begin
                  wait_cnt_d = wait_cnt_q + CNT_W'(1);
                  if (wait_cnt_d == CNT_W'(RETRY_LIMIT)) begin
                     stop_n_d = 1'b0;
                     trdy_n_d = 1'b1;
                  end
               end
`endif
            end
         end
         ST_TURNAROUND: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously by RST.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         frame_prev_q <= 1'b1;
         is_wr_q      <= 1'b0;
         index_q      <= 2'd0;
         devsel_n_q   <= 1'b1;
         trdy_n_q     <= 1'b1;
         st_re_q      <= 1'b0;
         st_we_q      <= 1'b0;
         st_addr_q    <= 2'd0;
         st_be_q      <= 4'd0;
      end else begin
         state_q      <= state_d;
         frame_prev_q <= FRAME_n;
         is_wr_q      <= is_wr_d;
         index_q      <= index_d;
         devsel_n_q   <= devsel_n_d;
         trdy_n_q     <= trdy_n_d;
         st_re_q      <= st_re_d;
         st_we_q      <= st_we_d;
         st_addr_q    <= st_addr_d;
         st_be_q      <= st_be_d;
      end
   end

`ifdef PCI_TGT_RETRY_EN
   // Wait-cycle counter and registered STOP#.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         stop_n_q   <= 1'b1;
         wait_cnt_q <= '0;
      end else begin
         stop_n_q   <= stop_n_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end
   assign STOP_n = stop_n_q;
`else
   assign STOP_n = 1'b1;
`endif

   assign DEVSEL_n    = devsel_n_q;
   assign TRDY_n      = trdy_n_q;
   assign st_re       = st_re_q;
   assign st_we       = st_we_q;
   assign st_addr     = st_addr_q;
   assign st_be       = st_be_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Bench for pci_target_ctrl: transaction-level master driver, a scoreboard
// of expected storage write strobes and directed plus random bursts.
module tb_pci_target_ctrl;
  import pci_pkg::*;

  localparam int NW = 3;
  localparam int RL = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        frame_n, irdy_n, st_ready;
  logic [31:0] ad;
  logic [3:0]  cbe_n;
  logic        devsel_n, trdy_n, stop_n, st_re, st_we;
  logic [1:0]  st_addr;
  logic [3:0]  st_be;
  logic [2:0]  state_dbg;

  pci_target_ctrl #(
    .BASE_ADDR   (32'h0000_1000),
    .NUM_WORDS   (NW),
    .RETRY_LIMIT (RL)
  ) dut (
    .clk         (clk),
    .RST         (rst),
    .FRAME_n     (frame_n),
    .IRDY_n      (irdy_n),
    .AD          (ad),
    .CBE_n       (cbe_n),
    .st_ready    (st_ready),
    .DEVSEL_n    (devsel_n),
    .TRDY_n      (trdy_n),
    .STOP_n      (stop_n),
    .st_re       (st_re),
    .st_we       (st_we),
    .st_addr     (st_addr),
    .st_be       (st_be),
    .state_dbg_o (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] exp_q[$];   // {word index, byte enables} of each expected st_we
  logic [5:0] mon_e;
  int consec_wait = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // storage readiness: random, never more than 3 consecutive waits
  task automatic rand_ready(output logic r);
    if (consec_wait >= 3) r = 1'b1;
    else r = ($urandom_range(0, 3) != 0);
    consec_wait = r ? 0 : consec_wait + 1;
  endtask

  // scoreboard: every write strobe must match the oldest expected phase
  always @(negedge clk) begin
    if (!rst && st_we) begin
      if (exp_q.size() == 0) begin
        check("we_unexpected", st_we, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("we_addr_be", {26'd0, st_addr, st_be}, {26'd0, mon_e});
      end
    end
  end

  // full claimed burst of n phases; byte enables taken nibble-wise from be_pack
  task automatic do_burst(input logic is_wr, input logic [31:0] addr, input int n,
                          input logic [31:0] be_pack, input logic all_ready);
    logic [1:0] idx;
    logic [3:0] be;
    logic ready, exp_trdy, done;
    int phase, cyc;
    idx = addr[3:2];
    phase = 0;
    cyc = 0;
    consec_wait = 0;
    frame_n = 1'b0; irdy_n = 1'b1; ad = addr;
    cbe_n = is_wr ? 4'b0111 : 4'b0110;
    st_ready = 1'b1;
    tick();  // address phase edge N
    check("decode_devsel", devsel_n, 1'b1);
    check("decode_trdy", trdy_n, 1'b1);
    be = be_pack[3:0];
    irdy_n = 1'b0; cbe_n = ~be; frame_n = (n == 1); ad = $urandom;
    if (all_ready) ready = 1'b1; else rand_ready(ready);
    st_ready = ready;
    tick();  // edge N+1
    check("claim_devsel", devsel_n, 1'b0);
    if (!is_wr) begin
      check("rdturn_trdy", trdy_n, 1'b1);
      check("rdturn_re", st_re, 1'b1);
      check("rdturn_addr", st_addr, idx);
      if (all_ready) ready = 1'b1; else rand_ready(ready);
      st_ready = ready;
      tick();  // edge N+2
    end
    exp_trdy = ~ready;
    while (phase < n && cyc < 100) begin
      check("data_trdy", trdy_n, exp_trdy);
      check("data_devsel", devsel_n, 1'b0);
      check("data_stop", stop_n, 1'b1);
      if (!is_wr) begin
        check("data_re", st_re, 1'b1);
        check("data_addr", st_addr, idx);
      end
      done = !exp_trdy;
      if (all_ready) ready = 1'b1; else rand_ready(ready);
      st_ready = ready;
      tick();
      cyc++;
      exp_trdy = ~ready;
      if (done) begin
        if (is_wr) exp_q.push_back({idx, be});
        idx = 2'((int'(idx) + 1) % NW);
        phase++;
        if (phase < n) begin
          be = be_pack[4*phase +: 4];
          cbe_n = ~be;
          frame_n = (phase == n - 1);
          ad = $urandom;
        end
      end
    end
    if (cyc >= 100) check("burst_timeout", cyc, 0);
    irdy_n = 1'b1; cbe_n = 4'hF; ad = '0; st_ready = 1'b1; frame_n = 1'b1;
    check("ta_devsel", devsel_n, 1'b1);
    check("ta_trdy", trdy_n, 1'b1);
    check("ta_re", st_re, 1'b0);
    tick();
    check("idle_state", state_dbg, ST_IDLE);
    check("we_drained", exp_q.size(), 0);
  endtask

  // address phase that must not be claimed
  task automatic do_miss(input logic [31:0] addr, input logic [3:0] cmd);
    frame_n = 1'b0; irdy_n = 1'b1; ad = addr; cbe_n = cmd; st_ready = 1'b1;
    tick();
    irdy_n = 1'b0; cbe_n = 4'h0; ad = $urandom;
    for (int i = 0; i < 4; i++) begin
      check("miss_devsel", devsel_n, 1'b1);
      check("miss_trdy", trdy_n, 1'b1);
      check("miss_re", st_re, 1'b0);
      check("miss_we", st_we, 1'b0);
      tick();
    end
    frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'hF;
    tick();
  endtask

  // write that stalls on storage; retry build must disconnect after RL waits
  task automatic do_stall();
    frame_n = 1'b0; irdy_n = 1'b1; ad = 32'h0000_1008; cbe_n = 4'b0111; st_ready = 1'b0;
    tick();
    irdy_n = 1'b0; cbe_n = 4'h0;
    tick();  // first DATA cycle
`ifdef PCI_TGT_RETRY_EN
    for (int k = 1; k <= RL; k++) begin
      check("retry_stop_pre", stop_n, 1'b1);
      check("retry_trdy_pre", trdy_n, 1'b1);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      check("retry_stop", stop_n, 1'b0);
      check("retry_trdy", trdy_n, 1'b1);
      check("retry_devsel", devsel_n, 1'b0);
      tick();
    end
    frame_n = 1'b1;
    tick();
    check("retry_ta_stop", stop_n, 1'b1);
    check("retry_ta_devsel", devsel_n, 1'b1);
    irdy_n = 1'b1;
    tick();
    check("retry_idle", state_dbg, ST_IDLE);
`else
    for (int k = 0; k < RL + 4; k++) begin
      check("wait_stop", stop_n, 1'b1);
      check("wait_trdy", trdy_n, 1'b1);
      check("wait_devsel", devsel_n, 1'b0);
      tick();
    end
    st_ready = 1'b1;
    tick();
    check("wait_end_trdy", trdy_n, 1'b0);
    frame_n = 1'b1;
    tick();
    exp_q.push_back({2'd2, 4'hF});
    irdy_n = 1'b1; cbe_n = 4'hF;
    check("wait_ta_devsel", devsel_n, 1'b1);
    tick();
    check("wait_idle", state_dbg, ST_IDLE);
    check("wait_we_drained", exp_q.size(), 0);
`endif
    frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'hF; st_ready = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [1:0] ridx;
    rst = 1'b1; frame_n = 1'b1; irdy_n = 1'b1; ad = '0; cbe_n = 4'hF; st_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_devsel", devsel_n, 1'b1);
    check("rst_trdy", trdy_n, 1'b1);
    check("rst_stop", stop_n, 1'b1);
    check("rst_re", st_re, 1'b0);
    check("rst_we", st_we, 1'b0);
    check("rst_addr", st_addr, 2'd0);
    check("rst_be", st_be, 4'd0);
    check("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    tick();

    do_burst(1'b1, 32'h0000_1000, 3, 32'h0000_0F2F, 1'b1);
    do_burst(1'b0, 32'h0000_1004, 4, 32'h0000_FFFF, 1'b1);
    do_miss(32'h0000_2000, 4'b0111);
    do_miss(32'h0000_100C, 4'b0111);
    do_miss(32'h0000_1000, 4'b0010);
    do_burst(1'b1, 32'h0000_1000, 3, 32'h0000_00F0, 1'b0);

    // reset during the second write phase
    frame_n = 1'b0; irdy_n = 1'b1; ad = 32'h0000_1000; cbe_n = 4'b0111; st_ready = 1'b1;
    tick();
    irdy_n = 1'b0; cbe_n = 4'h0;
    tick();
    check("rstmid_trdy", trdy_n, 1'b0);
    tick();
    exp_q.push_back({2'd0, 4'hF});
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_devsel", devsel_n, 1'b1);
    check("rstmid_trdy_rel", trdy_n, 1'b1);
    check("rstmid_we", st_we, 1'b0);
    check("rstmid_re", st_re, 1'b0);
    check("rstmid_addr", st_addr, 2'd0);
    check("rstmid_be", st_be, 4'd0);
    check("rstmid_state", state_dbg, ST_IDLE);
    tick();
    frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'hF;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_idle_devsel", devsel_n, 1'b1);
    end
    check("rstmid_drained", exp_q.size(), 0);
    do_burst(1'b1, 32'h0000_1004, 2, 32'h0000_0053, 1'b1);

    do_stall();
    tick();

    // master abort while storage stalls
    frame_n = 1'b0; irdy_n = 1'b1; ad = 32'h0000_1000; cbe_n = 4'b0111; st_ready = 1'b0;
    tick();
    irdy_n = 1'b0; cbe_n = 4'h0;
    tick();
    check("abort_devsel_on", devsel_n, 1'b0);
    frame_n = 1'b1; irdy_n = 1'b1;
    tick();
    check("abort_ta_devsel", devsel_n, 1'b1);
    check("abort_ta_trdy", trdy_n, 1'b1);
    st_ready = 1'b1;
    tick();
    check("abort_idle", state_dbg, ST_IDLE);

    for (int t = 0; t < 24; t++) begin
      ridx = 2'($urandom_range(0, NW - 1));
      if ($urandom_range(0, 5) == 0) do_miss(32'h0000_1000 | 32'hC, 4'b0110);
      else do_burst(1'($urandom_range(0, 1)), 32'h0000_1000 | {28'd0, ridx, 2'b00},
                    $urandom_range(1, 7), $urandom, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
